// File: rtl/alu_result_checker.sv
// alu_result_checker: watches the result side of a W-bit ALU. It recomputes the
// expected R/O/N/Z for every accepted transaction, compares them with what the
// ALU returned, counts vectors and failures, and keeps a copy of the first
// failing vector of each run.

module alu_result_checker #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [1:0]    ctrl,
    input  logic [W-1:0]  r,
    input  logic          o,
    input  logic          n,
    input  logic          z,
    output logic          mismatch,
    output logic [CW-1:0] vec_count,
    output logic [CW-1:0] err_count,
    output logic          fail_valid,
    output logic [W-1:0]  fail_a,
    output logic [W-1:0]  fail_b,
    output logic [1:0]    fail_ctrl,
    output logic [W-1:0]  fail_r,
    output logic [W-1:0]  fail_exp_r,
    output logic [5:0]    fail_flags,
    output logic          busy,
    output logic          done,
    output logic          pass
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t state_q, state_d;

    // stage 1: the accepted transaction as received
    logic          s1_valid_q, s1_valid_d;
    logic [W-1:0]  s1_a_q, s1_a_d;
    logic [W-1:0]  s1_b_q, s1_b_d;
    logic [1:0]    s1_ctrl_q, s1_ctrl_d;
    logic [W-1:0]  s1_r_q, s1_r_d;
    logic [2:0]    s1_onz_q, s1_onz_d;

    // stage 2: the transaction plus its expected result and flags
    logic          s2_valid_q, s2_valid_d;
    logic [W-1:0]  s2_a_q, s2_a_d;
    logic [W-1:0]  s2_b_q, s2_b_d;
    logic [1:0]    s2_ctrl_q, s2_ctrl_d;
    logic [W-1:0]  s2_r_q, s2_r_d;
    logic [2:0]    s2_onz_q, s2_onz_d;
    logic [W-1:0]  s2_exp_r_q, s2_exp_r_d;
    logic [2:0]    s2_exp_onz_q, s2_exp_onz_d;

    logic          mismatch_q, mismatch_d;
    logic [CW-1:0] vec_count_q, vec_count_d;
    logic [CW-1:0] err_count_q, err_count_d;
    logic          fail_valid_q, fail_valid_d;
    logic [W-1:0]  fail_a_q, fail_a_d;
    logic [W-1:0]  fail_b_q, fail_b_d;
    logic [1:0]    fail_ctrl_q, fail_ctrl_d;
    logic [W-1:0]  fail_r_q, fail_r_d;
    logic [W-1:0]  fail_exp_r_q, fail_exp_r_d;
    logic [5:0]    fail_flags_q, fail_flags_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;

    logic          accept;
    logic          retire;
    logic          vec_fail;
    logic [W-1:0]  exp_r;
    logic          exp_o;

    assign in_ready = (state_q == RUN);
    assign accept   = in_valid && in_ready;

    // Reference ALU model evaluated on the stage-1 transaction.
    always_comb begin
        exp_r = '0;
        exp_o = 1'b0;
        unique case (s1_ctrl_q)
            2'b00: begin
                exp_r = s1_a_q + s1_b_q;
                exp_o = (s1_a_q[W-1] == s1_b_q[W-1]) && (exp_r[W-1] != s1_a_q[W-1]);
            end
            2'b01: begin
                exp_r = s1_a_q - s1_b_q;
                exp_o = (s1_a_q[W-1] != s1_b_q[W-1]) && (exp_r[W-1] != s1_a_q[W-1]);
            end
            2'b10: exp_r = s1_a_q & s1_b_q;
            default: exp_r = s1_a_q | s1_b_q;
        endcase
    end

    // Next-state logic: control FSM, pipeline advance, counters and first-fail capture.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (start) state_d = RUN;
                     else if (stop) state_d = DRAIN;
            DRAIN:   if (start) state_d = RUN;
                     else if (!s1_valid_q) state_d = DONE;
            default: if (start) state_d = RUN;
        endcase

        // A start discards anything in flight, so the next run begins clean.
        s1_valid_d = accept && !start;
        s1_a_d     = accept ? a    : s1_a_q;
        s1_b_d     = accept ? b    : s1_b_q;
        s1_ctrl_d  = accept ? ctrl : s1_ctrl_q;
        s1_r_d     = accept ? r    : s1_r_q;
        s1_onz_d   = accept ? {o, n, z} : s1_onz_q;

        s2_valid_d   = s1_valid_q && !start;
        s2_a_d       = s1_valid_q ? s1_a_q    : s2_a_q;
        s2_b_d       = s1_valid_q ? s1_b_q    : s2_b_q;
        s2_ctrl_d    = s1_valid_q ? s1_ctrl_q : s2_ctrl_q;
        s2_r_d       = s1_valid_q ? s1_r_q    : s2_r_q;
        s2_onz_d     = s1_valid_q ? s1_onz_q  : s2_onz_q;
        s2_exp_r_d   = s1_valid_q ? exp_r     : s2_exp_r_q;
        s2_exp_onz_d = s1_valid_q ? {exp_o, exp_r[W-1], (exp_r == '0)} : s2_exp_onz_q;

        retire   = s2_valid_q && !start;
        vec_fail = (s2_r_q != s2_exp_r_q) || (s2_onz_q != s2_exp_onz_q);

        mismatch_d  = retire && vec_fail;
        vec_count_d = vec_count_q;
        err_count_d = err_count_q;
        if (start) begin
            vec_count_d = '0;
            err_count_d = '0;
        end else if (retire) begin
            if (vec_count_q != CNT_MAX) vec_count_d = vec_count_q + 1'b1;
            if (vec_fail && (err_count_q != CNT_MAX)) err_count_d = err_count_q + 1'b1;
        end

        fail_valid_d = fail_valid_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;
        fail_ctrl_d  = fail_ctrl_q;
        fail_r_d     = fail_r_q;
        fail_exp_r_d = fail_exp_r_q;
        fail_flags_d = fail_flags_q;
        if (start) begin
            fail_valid_d = 1'b0;
            fail_a_d     = '0;
            fail_b_d     = '0;
            fail_ctrl_d  = '0;
            fail_r_d     = '0;
            fail_exp_r_d = '0;
            fail_flags_d = '0;
        end else if (retire && vec_fail && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_a_d     = s2_a_q;
            fail_b_d     = s2_b_q;
            fail_ctrl_d  = s2_ctrl_q;
            fail_r_d     = s2_r_q;
            fail_exp_r_d = s2_exp_r_q;
            fail_flags_d = {s2_onz_q, s2_exp_onz_q};
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_count_d == '0);
    end

    // All state registers; reset abandons the run and everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_ctrl_q    <= '0;
            s1_r_q       <= '0;
            s1_onz_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_a_q       <= '0;
            s2_b_q       <= '0;
            s2_ctrl_q    <= '0;
            s2_r_q       <= '0;
            s2_onz_q     <= '0;
            s2_exp_r_q   <= '0;
            s2_exp_onz_q <= '0;
            mismatch_q   <= 1'b0;
            vec_count_q  <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_ctrl_q  <= '0;
            fail_r_q     <= '0;
            fail_exp_r_q <= '0;
            fail_flags_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_ctrl_q    <= s1_ctrl_d;
            s1_r_q       <= s1_r_d;
            s1_onz_q     <= s1_onz_d;
            s2_valid_q   <= s2_valid_d;
            s2_a_q       <= s2_a_d;
            s2_b_q       <= s2_b_d;
            s2_ctrl_q    <= s2_ctrl_d;
            s2_r_q       <= s2_r_d;
            s2_onz_q     <= s2_onz_d;
            s2_exp_r_q   <= s2_exp_r_d;
            s2_exp_onz_q <= s2_exp_onz_d;
            mismatch_q   <= mismatch_d;
            vec_count_q  <= vec_count_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
            fail_ctrl_q  <= fail_ctrl_d;
            fail_r_q     <= fail_r_d;
            fail_exp_r_q <= fail_exp_r_d;
            fail_flags_q <= fail_flags_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign mismatch   = mismatch_q;
    assign vec_count  = vec_count_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;
    assign fail_ctrl  = fail_ctrl_q;
    assign fail_r     = fail_r_q;
    assign fail_exp_r = fail_exp_r_q;
    assign fail_flags = fail_flags_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker. A second instance with CW=4 shares
// all inputs so that counter saturation can be observed in a short run.

module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  ctrl = '0;
    logic [31:0] r = '0;
    logic        o = 1'b0;
    logic        n = 1'b0;
    logic        z = 1'b0;

    logic        in_ready, mismatch, fail_valid, busy, done, pass;
    logic [15:0] vec_count, err_count;
    logic [31:0] fail_a, fail_b, fail_r, fail_exp_r;
    logic [1:0]  fail_ctrl;
    logic [5:0]  fail_flags;

    logic        in_ready4, mismatch4, fail_valid4, busy4, done4, pass4;
    logic [3:0]  vec_count4, err_count4;
    logic [31:0] fail_a4, fail_b4, fail_r4, fail_exp_r4;
    logic [1:0]  fail_ctrl4;
    logic [5:0]  fail_flags4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_result_checker #(.W(32), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ctrl(ctrl), .r(r), .o(o), .n(n), .z(z),
        .mismatch(mismatch), .vec_count(vec_count), .err_count(err_count),
        .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b),
        .fail_ctrl(fail_ctrl), .fail_r(fail_r), .fail_exp_r(fail_exp_r),
        .fail_flags(fail_flags), .busy(busy), .done(done), .pass(pass)
    );

    alu_result_checker #(.W(32), .CW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .ctrl(ctrl), .r(r), .o(o), .n(n), .z(z),
        .mismatch(mismatch4), .vec_count(vec_count4), .err_count(err_count4),
        .fail_valid(fail_valid4), .fail_a(fail_a4), .fail_b(fail_b4),
        .fail_ctrl(fail_ctrl4), .fail_r(fail_r4), .fail_exp_r(fail_exp_r4),
        .fail_flags(fail_flags4), .busy(busy4), .done(done4), .pass(pass4)
    );

    // advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setVec(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vc,
                          input logic [31:0] vr, input logic [2:0] vonz);
        a = va; b = vb; ctrl = vc; r = vr; {o, n, z} = vonz;
    endtask

    // one transaction accepted at the next edge, then in_valid dropped
    task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vc,
                                 input logic [31:0] vr, input logic [2:0] vonz);
        setVec(va, vb, vc, vr, vonz);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        // reset state
        step();
        step();
        checkOutput("rst_vec", vec_count, 0);
        checkOutput("rst_err", err_count, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", in_ready, 0);
        checkOutput("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        // run 1
        start = 1'b1; step(); start = 1'b0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_ready", in_ready, 1);

        applyStimulus(32'hfffff021, 32'hffffffff, 2'b00, 32'hfffff020, 3'b010);
        checkOutput("v1_k_vec", vec_count, 0);
        step();
        checkOutput("v1_k1_vec", vec_count, 0);
        step();
        checkOutput("v1_vec", vec_count, 1);
        checkOutput("v1_err", err_count, 0);
        checkOutput("v1_mm", mismatch, 0);

        applyStimulus(32'h76767676, 32'h23144321, 2'b00, 32'h998ab997, 3'b110);
        step(); step();
        checkOutput("v2_vec", vec_count, 2);
        checkOutput("v2_err", err_count, 0);
        checkOutput("v2_mm", mismatch, 0);

        applyStimulus(32'h76767676, 32'h23144321, 2'b00, 32'h998ab997, 3'b010);
        step(); step();
        checkOutput("v3_mm", mismatch, 1);
        checkOutput("v3_err", err_count, 1);
        checkOutput("v3_vec", vec_count, 3);
        checkOutput("v3_fvalid", fail_valid, 1);
        checkOutput("v3_fflags", fail_flags, 6'b010110);
        checkOutput("v3_fa", fail_a, 32'h76767676);
        checkOutput("v3_fexp", fail_exp_r, 32'h998ab997);
        step();
        checkOutput("v3_mm_low", mismatch, 0);

        // run 2: new start clears capture
        start = 1'b1; step(); start = 1'b0;
        checkOutput("r2_vec", vec_count, 0);
        checkOutput("r2_err", err_count, 0);
        checkOutput("r2_fvalid", fail_valid, 0);

        applyStimulus(32'hffffffff, 32'hffffffff, 2'b01, 32'h00000000, 3'b001);
        step(); step();
        checkOutput("v4_vec", vec_count, 1);
        checkOutput("v4_err", err_count, 0);

        applyStimulus(32'hffffffff, 32'h0a0ab0b0, 2'b10, 32'h0a0ab0b1, 3'b000);
        step(); step();
        checkOutput("v5_err", err_count, 1);
        checkOutput("v5_fexp", fail_exp_r, 32'h0a0ab0b0);
        checkOutput("v5_fr", fail_r, 32'h0a0ab0b1);
        checkOutput("v5_fctrl", fail_ctrl, 2'b10);
        checkOutput("v5_fflags", fail_flags, 6'b000000);

        applyStimulus(32'h0000f000, 32'h0000000f, 2'b11, 32'h0000f00f, 3'b001);
        step(); step();
        checkOutput("v6_err", err_count, 2);
        checkOutput("v6_mm", mismatch, 1);
        checkOutput("v6_fr_held", fail_r, 32'h0a0ab0b1);
        checkOutput("v6_fctrl_held", fail_ctrl, 2'b10);

        // run 3: ten back-to-back OR vectors, stop with the last
        start = 1'b1; step(); start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            setVec(i, i << 8, 2'b11, i | (i << 8), 3'b000);
            in_valid = 1'b1;
            stop = (i == 10);
            step();
        end
        in_valid = 1'b0;
        stop = 1'b0;
        checkOutput("b2b_drain_busy", busy, 1);
        checkOutput("b2b_drain_ready", in_ready, 0);
        checkOutput("b2b_drain_vec", vec_count, 8);
        step();
        checkOutput("b2b_drain2_busy", busy, 1);
        checkOutput("b2b_drain2_done", done, 0);
        step();
        checkOutput("b2b_done", done, 1);
        checkOutput("b2b_busy", busy, 0);
        checkOutput("b2b_vec", vec_count, 10);
        checkOutput("b2b_err", err_count, 0);
        checkOutput("b2b_pass", pass, 1);

        // in_valid in DONE is ignored
        setVec(32'hfffff021, 32'hffffffff, 2'b00, 32'hfffff020, 3'b010);
        in_valid = 1'b1;
        step(); step(); step();
        in_valid = 1'b0;
        checkOutput("done_ignore_vec", vec_count, 10);

        // start and stop together: start wins
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        checkOutput("ss_ready", in_ready, 1);
        checkOutput("ss_vec", vec_count, 0);
        checkOutput("ss_done", done, 0);

        // start during DRAIN clears counters
        applyStimulus(32'h76767676, 32'h23144321, 2'b00, 32'h998ab997, 3'b010);
        step(); step();
        checkOutput("dr_err_pre", err_count, 1);
        stop = 1'b1; step(); stop = 1'b0;
        checkOutput("dr_busy", busy, 1);
        checkOutput("dr_ready", in_ready, 0);
        start = 1'b1; step(); start = 1'b0;
        checkOutput("dr_vec", vec_count, 0);
        checkOutput("dr_err", err_count, 0);
        checkOutput("dr_fvalid", fail_valid, 0);
        checkOutput("dr_ready_run", in_ready, 1);

        // asynchronous reset between edges
        applyStimulus(32'h76767676, 32'h23144321, 2'b00, 32'h998ab997, 3'b010);
        in_valid = 1'b1;
        step(); step();
        checkOutput("ar_pre_err", err_count, 1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("ar_vec", vec_count, 0);
        checkOutput("ar_err", err_count, 0);
        checkOutput("ar_mm", mismatch, 0);
        checkOutput("ar_fvalid", fail_valid, 0);
        checkOutput("ar_fa", fail_a, 0);
        checkOutput("ar_busy", busy, 0);
        checkOutput("ar_ready", in_ready, 0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // in_valid while IDLE is ignored
        setVec(32'hfffff021, 32'hffffffff, 2'b00, 32'hfffff020, 3'b010);
        in_valid = 1'b1;
        step(); step(); step();
        in_valid = 1'b0;
        step(); step();
        checkOutput("idle_vec", vec_count, 0);
        checkOutput("idle_busy", busy, 0);

        // saturation: twenty failing vectors
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            setVec(32'h76767676, 32'h23144321, 2'b00, 32'h998ab997, 3'b010);
            in_valid = 1'b1;
            stop = (i == 19);
            step();
        end
        in_valid = 1'b0;
        stop = 1'b0;
        step(); step();
        checkOutput("sat4_err", err_count4, 15);
        checkOutput("sat4_vec", vec_count4, 15);
        checkOutput("sat4_done", done4, 1);
        checkOutput("sat4_pass", pass4, 0);
        checkOutput("sat16_err", err_count, 20);
        checkOutput("sat16_vec", vec_count, 20);
        checkOutput("sat16_pass", pass, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Hardware self-checking monitor on the ALU's result side.
- Accepts one ALU transaction per cycle: operands and CTRL sent to the ALU, plus the observed R/O/N/Z it returned.
- Recomputes the expected result and flags internally, compares them with the observed values, counts vectors and mismatches, and latches the first failing vector.
- Replaces the printed-monitor style of checking with a pass/fail verdict usable in regressions and on FPGA.

Parameters:
- W, 32, ALU data width. Must match the ALU's W.
- CW, 16, width of the vector counter and the error counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; clears counters and capture registers, enters RUN
- stop  input  1  one-cycle pulse; ends the run once the pipeline drains
- in_valid  input  1  transaction present on a/b/ctrl/r/o/n/z
- in_ready  output  1  checker accepts a transaction this cycle
- a  input  W  operand A driven to the ALU
- b  input  W  operand B driven to the ALU
- ctrl  input  2  ALU op: 00 add, 01 sub (A-B), 10 AND, 11 OR
- r  input  W  observed ALU result
- o  input  1  observed overflow flag
- n  input  1  observed negative flag
- z  input  1  observed zero flag
- mismatch  output  1  one-cycle pulse per failing vector
- vec_count  output  CW  vectors checked
- err_count  output  CW  vectors failed
- fail_valid  output  1  first-fail registers hold data
- fail_a  output  W  A of the first failing vector
- fail_b  output  W  B of the first failing vector
- fail_ctrl  output  2  CTRL of the first failing vector
- fail_r  output  W  observed R of the first failing vector
- fail_exp_r  output  W  expected R of the first failing vector
- fail_flags  output  6  {obs o,n,z, exp o,n,z} of the first failing vector
- busy  output  1  state is RUN or DRAIN
- done  output  1  state is DONE
- pass  output  1  done and err_count==0

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including all counters and capture registers.
  - Both pipeline valid bits are cleared.
  - Reset during RUN abandons the run and any in-flight vectors.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN on stop.
  - DRAIN -> DONE when both pipeline stages are empty (at most 2 cycles).
  - DONE -> RUN on start.
- Simultaneous and repeated control events:
  - start and stop in the same cycle: start wins.
  - start while in RUN or DRAIN: restart. Counters, capture registers and pipeline valids are cleared, and state goes to RUN.
- Handshake:
  - in_ready = (state==RUN).
  - A transfer occurs when in_valid && in_ready.
  - in_valid in any other state is ignored.
  - A transfer in the same cycle as stop is accepted and checked.
- Pipeline:
  - Stage 1 registers the accepted transaction.
  - Stage 2 registers the expected R/O/N/Z computed from stage 1.
  - The compare result is visible 2 cycles after acceptance: a transfer at edge k updates mismatch, vec_count, err_count and the fail_* registers at edge k+2.
  - Throughput is one vector per cycle.
- Expected-value model (all arithmetic modulo 2^W, operands two's complement):
  - add: R=A+B; O=(A[W-1]==B[W-1]) && (R[W-1]!=A[W-1]).
  - sub: R=A-B; O=(A[W-1]!=B[W-1]) && (R[W-1]!=A[W-1]).
  - AND/OR: bitwise R; O=0.
  - All ops: N=R[W-1]; Z=(R==0).
  - A vector fails if any of R, O, N, Z differs from expected.
- Counters:
  - vec_count increments per checked vector; err_count increments per failing vector.
  - Both saturate at 2^CW-1 and never wrap.
- First fail:
  - The fail_* registers load only on the first failing vector of a run, and fail_valid is set at the same time.
  - They are held until start or reset.
- Status outputs:
  - mismatch is high for exactly the cycle in which err_count updates.
  - pass and done are registered decodes of state and err_count.

Test Plan:
- Reset, start, then add vector a=fffff021, b=ffffffff, r=fffff020, onz=010 -> at k+2: vec_count=1, err_count=0, mismatch stays 0.
- Add overflow vector a=76767676, b=23144321, r=998ab997, onz=110 -> passes. The same vector with o=0 -> mismatch pulse, err_count=1, fail_flags=010_110.
- Sub vector a=ffffffff, b=ffffffff, r=00000000, z=1 -> passes. Then a corrupted AND vector a=ffffffff, b=0a0ab0b0, r=0a0ab0b1 -> fail_exp_r=0a0ab0b0. A second failure afterwards leaves the fail_* registers unchanged.
- Ten back-to-back vectors with in_valid held high, stop asserted alongside the last one -> state passes through DRAIN for 2 cycles, then done=1, vec_count=10, pass reflects err_count.
- Exercise control edge cases:
  - start and stop in the same cycle -> state goes to RUN.
  - start during DRAIN -> counters go to 0.
  - in_valid in IDLE -> no count.
  - rst_n low mid-stream (asynchronous, between edges) -> all outputs 0 immediately.
- With CW=4, feed 20 failing vectors -> err_count=15 and vec_count=15, both saturated.
